// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: takes the host ioctl byte stream for the ROM image,
// buffers it in a small FIFO, and paces one-byte writes onto the shared ROM
// download bus (dlad/dldt/dlen). Holds the game CPUs in reset until the
// whole image has been written. Also reports rejected bytes, a byte count
// and a running byte sum.
module rom_dl_sequencer #(
  parameter logic [7:0]  ROM_INDEX = 8'h00,
  parameter logic [17:0] ROM_SIZE  = 18'h24020,
  parameter int          FD        = 4,
  parameter int          WR_GAP    = 0
) (
  input  logic        dlcl,
  input  logic        rst_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [17:0] dlad,
  output logic [7:0]  dldt,
  output logic        dlen,
  output logic        cpu_rst,
  output logic        dl_done,
  output logic        dl_err,
  output logic [17:0] byte_cnt,
  output logic [31:0] sum
);

  localparam int         AW       = $clog2(FD);
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FD);
  localparam logic [AW:0] CNT_WAIT = (AW+1)'(FD - 2);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [3:0]  GAP_LOAD = 4'(WR_GAP);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_r, state_nx_s;
  logic          sel_s, sel_r, start_s, fin_s, entry_s;
  logic          active_s, wr_try_s, bad_s, push_s, pop_s;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r, count_nx_s;
  logic [3:0]    gap_r;
  logic [25:0]   mem_r [FD];
  logic [25:0]   head_s;

  assign sel_s   = ioctl_download & (ioctl_index == ROM_INDEX);
  assign start_s = sel_s & ~sel_r;
  assign fin_s   = ~sel_s & sel_r;
  // A fresh start always re-arms the download, even while still flushing.
  assign entry_s = start_s & (state_r != ST_LOAD);

  // Next-state selection for the download phase machine.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_s) state_nx_s = ST_LOAD; else state_nx_s = ST_IDLE;
      ST_LOAD:  if (fin_s) state_nx_s = ST_FLUSH; else state_nx_s = ST_LOAD;
      ST_FLUSH: begin
        if (start_s) state_nx_s = ST_LOAD;
        else if ((count_r == CNT_ZERO) && !dlen) state_nx_s = ST_DONE;
        else state_nx_s = ST_FLUSH;
      end
      ST_DONE:  if (start_s) state_nx_s = ST_LOAD; else state_nx_s = ST_DONE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Push/pop decisions and the FIFO occupancy after this edge.
  always_comb begin
    active_s = (state_r == ST_LOAD) | (state_r == ST_FLUSH);
    wr_try_s = (state_r == ST_LOAD) & ioctl_wr & sel_s;
    bad_s    = wr_try_s & ((ioctl_addr >= {7'd0, ROM_SIZE}) | (count_r == CNT_FULL));
    push_s   = wr_try_s & ~bad_s;
    pop_s    = active_s & (count_r != CNT_ZERO) & (gap_r == 4'd0) & ~entry_s;
    head_s   = mem_r[rd_ptr_r];
    if (entry_s) begin
      count_nx_s = CNT_ZERO;
    end else if (push_s & ~pop_s) begin
      count_nx_s = count_r + CNT_ONE;
    end else if (pop_s & ~push_s) begin
      count_nx_s = count_r - CNT_ONE;
    end else begin
      count_nx_s = count_r;
    end
  end

  // Phase register and the one-cycle delayed select used for edge detection.
  always_ff @(posedge dlcl or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sel_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      sel_r   <= sel_s;
    end
  end

  // FIFO storage and pointers; a new download drops anything left over.
  always_ff @(posedge dlcl or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
      for (int i = 0; i < FD; i++) mem_r[i] <= 26'd0;
    end else if (entry_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      count_r <= count_nx_s;
      if (push_s) begin
        mem_r[wr_ptr_r] <= {ioctl_addr[17:0], ioctl_dout};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Write pacing: enforce WR_GAP idle cycles after each bus write.
  always_ff @(posedge dlcl or negedge rst_n) begin
    if (!rst_n) begin
      gap_r <= 4'd0;
    end else if (entry_s) begin
      gap_r <= 4'd0;
    end else if (pop_s) begin
      gap_r <= GAP_LOAD;
    end else if (gap_r != 4'd0) begin
      gap_r <= gap_r - 4'd1;
    end
  end

  // ROM bus drive: address/data hold between pulses, dlen is a single-cycle strobe.
  always_ff @(posedge dlcl or negedge rst_n) begin
    if (!rst_n) begin
      dlad <= 18'd0;
      dldt <= 8'd0;
      dlen <= 1'b0;
    end else begin
      dlen <= pop_s;
      if (pop_s) begin
        dlad <= head_s[25:8];
        dldt <= head_s[7:0];
      end
    end
  end

  // Per-download statistics, cleared when a new download starts.
  always_ff @(posedge dlcl or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 18'd0;
      sum      <= 32'd0;
      dl_err   <= 1'b0;
    end else if (entry_s) begin
      byte_cnt <= 18'd0;
      sum      <= 32'd0;
      dl_err   <= 1'b0;
    end else begin
      if (pop_s) begin
        byte_cnt <= byte_cnt + 18'd1;
        sum      <= sum + {24'd0, head_s[7:0]};
      end
      if (bad_s) dl_err <= 1'b1;
    end
  end

  // Host back-pressure and CPU hold flags, derived from the phase being entered.
  always_ff @(posedge dlcl or negedge rst_n) begin
    if (!rst_n) begin
      ioctl_wait <= 1'b0;
      cpu_rst    <= 1'b1;
      dl_done    <= 1'b0;
    end else begin
      ioctl_wait <= ((state_nx_s == ST_LOAD) | (state_nx_s == ST_FLUSH)) &
                    (count_nx_s >= CNT_WAIT);
      cpu_rst    <= (state_nx_s != ST_DONE);
      dl_done    <= (state_nx_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Bench for rom_dl_sequencer: two instances share the host stimulus, one with
// WR_GAP=0 and one with WR_GAP=3. A queue-style model per instance predicts
// every output each cycle; directed scenarios add constant checks.
module tb_rom_dl_sequencer;

  localparam int          FD        = 4;
  localparam logic [7:0]  ROM_INDEX = 8'h00;
  localparam logic [17:0] ROM_SIZE  = 18'h24020;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_FLUSH = 2, PH_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic [1:0]        wt, dlen, cpu_rst, dl_done, dl_err;
  logic [1:0][17:0]  dlad, byte_cnt;
  logic [1:0][7:0]   dldt;
  logic [1:0][31:0]  sum;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state
  int          gapcfg [2] = '{0, 3};
  logic [25:0] m_buf  [2][FD];
  int          m_head [2], m_size [2], m_gap [2], m_ph [2];
  logic        m_sel  [2];
  logic        e_wait [2], e_dlen [2], e_cpu [2], e_done [2], e_err [2];
  logic [17:0] e_dlad [2], e_cnt [2];
  logic [7:0]  e_dldt [2];
  logic [31:0] e_sum  [2];

  logic [25:0] mon0 [$];
  logic [25:0] mon1 [$];
  int          t1q  [$];

  always #5 clk = ~clk;

  rom_dl_sequencer #(.ROM_INDEX(ROM_INDEX), .ROM_SIZE(ROM_SIZE), .FD(FD), .WR_GAP(0)) dut0 (
    .dlcl(clk), .rst_n(rst_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(wt[0]), .dlad(dlad[0]), .dldt(dldt[0]), .dlen(dlen[0]), .cpu_rst(cpu_rst[0]),
    .dl_done(dl_done[0]), .dl_err(dl_err[0]), .byte_cnt(byte_cnt[0]), .sum(sum[0]));

  rom_dl_sequencer #(.ROM_INDEX(ROM_INDEX), .ROM_SIZE(ROM_SIZE), .FD(FD), .WR_GAP(3)) dut1 (
    .dlcl(clk), .rst_n(rst_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(wt[1]), .dlad(dlad[1]), .dldt(dldt[1]), .dlen(dlen[1]), .cpu_rst(cpu_rst[1]),
    .dl_done(dl_done[1]), .dl_err(dl_err[1]), .byte_cnt(byte_cnt[1]), .sum(sum[1]));

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset(input int k);
    m_ph[k] = PH_IDLE; m_head[k] = 0; m_size[k] = 0; m_gap[k] = 0; m_sel[k] = 1'b0;
    e_wait[k] = 1'b0; e_dlen[k] = 1'b0; e_cpu[k] = 1'b1; e_done[k] = 1'b0; e_err[k] = 1'b0;
    e_dlad[k] = 18'd0; e_dldt[k] = 8'd0; e_cnt[k] = 18'd0; e_sum[k] = 32'd0;
  endtask

  // One clock edge worth of behaviour, straight from the download rules.
  task automatic model_step(input int k);
    logic sel, st, fin, accept, old_dlen;
    logic [25:0] head;
    int old_size;
    sel      = ioctl_download && (ioctl_index == ROM_INDEX);
    st       = sel && !m_sel[k];
    fin      = !sel && m_sel[k];
    old_dlen = e_dlen[k];
    if (st && m_ph[k] != PH_LOAD) begin
      m_size[k] = 0; m_head[k] = 0; m_gap[k] = 0;
      e_err[k] = 1'b0; e_cnt[k] = 18'd0; e_sum[k] = 32'd0; e_dlen[k] = 1'b0;
      m_ph[k] = PH_LOAD;
    end else begin
      old_size = m_size[k];
      accept = 1'b0;
      if (m_ph[k] == PH_LOAD && ioctl_wr && sel) begin
        if (ioctl_addr >= {7'd0, ROM_SIZE} || old_size == FD) e_err[k] = 1'b1;
        else accept = 1'b1;
      end
      if ((m_ph[k] == PH_LOAD || m_ph[k] == PH_FLUSH) && old_size > 0 && m_gap[k] == 0) begin
        head = m_buf[k][m_head[k]];
        m_head[k] = (m_head[k] + 1) % FD;
        m_size[k]--;
        e_dlad[k] = head[25:8];
        e_dldt[k] = head[7:0];
        e_dlen[k] = 1'b1;
        e_cnt[k]  = e_cnt[k] + 18'd1;
        e_sum[k]  = e_sum[k] + {24'd0, head[7:0]};
        m_gap[k]  = gapcfg[k];
      end else begin
        e_dlen[k] = 1'b0;
        if (m_gap[k] > 0) m_gap[k]--;
      end
      if (accept) begin
        m_buf[k][(m_head[k] + m_size[k]) % FD] = {ioctl_addr[17:0], ioctl_dout};
        m_size[k]++;
      end
      if (m_ph[k] == PH_LOAD && fin) m_ph[k] = PH_FLUSH;
      else if (m_ph[k] == PH_FLUSH && old_size == 0 && !old_dlen) m_ph[k] = PH_DONE;
    end
    m_sel[k]  = sel;
    e_wait[k] = (m_ph[k] == PH_LOAD || m_ph[k] == PH_FLUSH) && (m_size[k] >= FD - 2);
    e_cpu[k]  = (m_ph[k] != PH_DONE);
    e_done[k] = (m_ph[k] == PH_DONE);
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset(k);
      else model_step(k);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("outs%0d", k),
        {wt[k], dlad[k], dldt[k], dlen[k], cpu_rst[k], dl_done[k], dl_err[k], byte_cnt[k], sum[k]},
        {e_wait[k], e_dlad[k], e_dldt[k], e_dlen[k], e_cpu[k], e_done[k], e_err[k], e_cnt[k], e_sum[k]});
    end
    if (dlen[0]) mon0.push_back({dlad[0], dldt[0]});
    if (dlen[1]) begin
      mon1.push_back({dlad[1], dldt[1]});
      t1q.push_back(cyc);
    end
  endtask

  initial begin
    int n, guard, c0, c1, nb, gp;
    logic honor;
    logic [24:0] a;
    rst_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00;
    ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
    model_reset(0); model_reset(1);
    repeat (3) tick();
    check_eq("reset_flags", {wt, dlen, cpu_rst, dl_done, dl_err}, {2'b00, 2'b00, 2'b11, 2'b00, 2'b00});
    rst_n = 1'b1;
    tick();

    // 1: 16 contiguous bytes
    mon0.delete();
    ioctl_download = 1'b1; tick();
    for (int i = 0; i < 16; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(8'h10 + i); tick();
    end
    ioctl_wr = 1'b0; tick();
    ioctl_download = 1'b0;
    repeat (40) tick();
    check_eq("t1_npulses", 128'(mon0.size()), 128'd16);
    for (int i = 0; i < 16 && i < mon0.size(); i++)
      check_eq($sformatf("t1_order%0d", i), 128'(mon0[i]), 128'({18'(i), 8'(8'h10 + i)}));
    check_eq("t1_cnt", 128'(byte_cnt[0]), 128'd16);
    check_eq("t1_sum", 128'(sum[0]), 128'h178);
    check_eq("t1_done_cpu", {dl_done[0], cpu_rst[0]}, {1'b1, 1'b0});

    // 2: out-of-range byte
    ioctl_download = 1'b1; tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'hA5; tick();
    ioctl_addr = 25'h24020; ioctl_dout = 8'h3C; tick();
    ioctl_wr = 1'b0;
    repeat (6) tick();
    check_eq("t2_err", 128'(dl_err[0]), 128'd1);
    check_eq("t2_cnt", 128'(byte_cnt[0]), 128'd1);
    ioctl_download = 1'b0;
    repeat (10) tick();

    // 3: WR_GAP=3, host honours back-pressure
    mon1.delete(); t1q.delete();
    ioctl_download = 1'b1; tick();
    n = 0; guard = 0;
    while (n < 8 && guard < 200) begin
      if (!wt[1]) begin
        ioctl_wr = 1'b1; ioctl_addr = 25'(n); ioctl_dout = 8'($urandom); n++;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick(); guard++;
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    repeat (40) tick();
    check_eq("t3_sent", 128'(n), 128'd8);
    check_eq("t3_npulses", 128'(t1q.size()), 128'd8);
    for (int i = 1; i < t1q.size(); i++)
      check_eq($sformatf("t3_space%0d", i), 128'(t1q[i] - t1q[i-1]), 128'd4);
    for (int i = 0; i < mon1.size(); i++)
      check_eq($sformatf("t3_addr%0d", i), 128'(mon1[i][25:8]), 128'(i));
    check_eq("t3_err", 128'(dl_err[1]), 128'd0);

    // 4: host ignores back-pressure, overflow on the gapped instance
    mon1.delete();
    ioctl_download = 1'b1; tick();
    for (int i = 0; i < 8; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(12'h100 + i); ioctl_dout = 8'(i); tick();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    repeat (40) tick();
    check_eq("t4_err1", 128'(dl_err[1]), 128'd1);
    check_eq("t4_cnt1", 128'(byte_cnt[1]), 128'd6);
    check_eq("t4_err0", {dl_err[0], byte_cnt[0]}, {1'b0, 18'd8});
    if (mon1.size() == 6) begin
      check_eq("t4_a4", 128'(mon1[4][25:8]), 128'h104);
      check_eq("t4_a5", 128'(mon1[5][25:8]), 128'h106);
    end else begin
      check_eq("t4_npulses", 128'(mon1.size()), 128'd6);
    end

    // 5: wrong index from IDLE
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    c0 = mon0.size(); c1 = mon1.size();
    ioctl_index = 8'h01; ioctl_download = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i + 1); tick();
    end
    ioctl_wr = 1'b0; tick(); ioctl_download = 1'b0;
    repeat (5) tick();
    check_eq("t5_nodlen", 128'(mon0.size() + mon1.size()), 128'(c0 + c1));
    check_eq("t5_flags", {cpu_rst, dl_done}, {2'b11, 2'b00});
    ioctl_index = 8'h00;

    // 6: async reset mid-load
    ioctl_download = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(8'hC0 + i); tick();
    end
    #2;
    rst_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    #1;
    check_eq("t6_rst_flags", {wt, dlen, cpu_rst, dl_done, dl_err}, {2'b00, 2'b00, 2'b11, 2'b00, 2'b00});
    check_eq("t6_rst_data", {dlad, dldt, byte_cnt}, 128'd0);
    check_eq("t6_rst_sum", 128'(sum), 128'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    c0 = mon0.size(); c1 = mon1.size();
    repeat (10) tick();
    check_eq("t6_nodlen", 128'(mon0.size() + mon1.size()), 128'(c0 + c1));

    // random windows, short gaps exercise restart during flush
    for (int w = 0; w < 30; w++) begin
      ioctl_index = ($urandom_range(0, 4) == 0) ? 8'h01 : 8'h00;
      ioctl_download = 1'b1;
      honor = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 14);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 7) == 0) a = 25'h24020 + 25'($urandom_range(0, 40));
        else a = 25'($urandom_range(0, 32'h2401F));
        ioctl_addr = a;
        ioctl_dout = 8'($urandom);
        ioctl_wr = ($urandom_range(0, 3) != 0) && !(honor && wt[1]);
        tick();
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      gp = $urandom_range(1, 20);
      repeat (gp) tick();
    end
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
